// File: rtl/control_sequencer_pkg.sv
// Shared constants for the control sequencer: ALU op codes, instruction opcodes,
// step numbers and the single-bit control-word bundle with its helper functions.
package control_sequencer_pkg;

  localparam logic [3:0] ALU_PASS = 4'h0;
  localparam logic [3:0] ALU_ADD  = 4'h1;
  localparam logic [3:0] ALU_SUB  = 4'h2;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_LOD   = 8'h02;
  localparam logic [7:0] OP_MOVAB = 8'h03;
  localparam logic [7:0] OP_MOVBA = 8'h04;
  localparam logic [7:0] OP_WRITE = 8'h05;
  localparam logic [7:0] OP_SUB   = 8'h06;
  localparam logic [7:0] OP_STO   = 8'h07;
  localparam logic [7:0] OP_JMP   = 8'h08;
  localparam logic [7:0] OP_JZ    = 8'h09;
  localparam logic [7:0] OP_JC    = 8'h0A;
  localparam logic [7:0] OP_HLT   = 8'h0B;

  localparam logic [1:0] STEP_FETCH = 2'd0;
  localparam logic [1:0] STEP_1     = 2'd1;
  localparam logic [1:0] STEP_2     = 2'd2;

  typedef struct packed {
    logic data_in;
    logic data_out;
    logic a_latch;
    logic a_enable;
    logic a_read_alu;
    logic b_latch;
    logic b_enable;
    logic ip_latch;
    logic ip_enable;
    logic ip_inc;
    logic ir_latch;
    logic addr_latch;
    logic d_latch;
    logic d_enable;
    logic d_inc;
    logic d_in_select;
    logic d_out_select;
  } ctrl_t;

  // Operand fetch at IP, advancing IP past it.
  function automatic ctrl_t fetch_byte();
    ctrl_t c;
    c = '0;
    c.ip_enable  = 1'b1;
    c.addr_latch = 1'b1;
    c.data_in    = 1'b1;
    c.ip_inc     = 1'b1;
    return c;
  endfunction

  // Drop strobes that would commit state at the edge while memory is not ready.
  function automatic ctrl_t gate_commit(ctrl_t c);
    ctrl_t g;
    g = c;
    g.ip_inc   = 1'b0;
    g.ip_latch = 1'b0;
    g.ir_latch = 1'b0;
    g.a_latch  = 1'b0;
    g.b_latch  = 1'b0;
    g.d_latch  = 1'b0;
    return g;
  endfunction

endpackage

// File: rtl/control_sequencer_step_counter.sv
// Step register: async clear, holds on stall/halt, otherwise advances or returns to 0 on done.
module step_counter #(
  parameter int STEP_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  done,
  output logic [STEP_WIDTH-1:0] step
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step <= '0;
    end else if (!hold) begin
      if (done) step <= '0;
      else      step <= step + STEP_WIDTH'(1);
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Instruction decoder producing per-step control strobes; 2-3 steps per instruction.
// Memory steps stall on MEM_READY=0 with edge-committing strobes withheld.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int OPCODE_WIDTH = 8,
  parameter int ALU_OP_WIDTH = 4,
  parameter int STEP_WIDTH   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] INST,
  input  logic                    MEM_READY,
  input  logic                    FLAG_Z,
  input  logic                    FLAG_C,
  output logic                    DATA_IN,
  output logic                    DATA_OUT,
  output logic [ALU_OP_WIDTH-1:0] ALU_OP,
  output logic                    A_LATCH,
  output logic                    A_ENABLE,
  output logic                    A_READ_ALU,
  output logic                    B_LATCH,
  output logic                    B_ENABLE,
  output logic                    IP_LATCH,
  output logic                    IP_ENABLE,
  output logic                    IP_INC,
  output logic                    IR_LATCH,
  output logic                    ADDR_LATCH,
  output logic                    D_LATCH,
  output logic                    D_ENABLE,
  output logic                    D_INC,
  output logic                    D_IN_SELECT,
  output logic                    D_OUT_SELECT,
  output logic                    HALTED,
  output logic                    ILLEGAL
);

  logic [STEP_WIDTH-1:0]   step;
  logic                    halted;
  logic                    done;
  logic                    halt_req;
  logic                    illegal_c;
  logic                    mem_step;
  logic                    stall;
  logic [ALU_OP_WIDTH-1:0] alu_op;
  ctrl_t                   raw;
  ctrl_t                   ctrl;

  always_comb begin
    raw       = '0;
    alu_op    = '0;
    done      = 1'b0;
    halt_req  = 1'b0;
    illegal_c = 1'b0;
    if (halted) begin
      done = 1'b0;
    end else if (step == STEP_WIDTH'(STEP_FETCH)) begin
      raw.data_in    = 1'b1;
      raw.ip_enable  = 1'b1;
      raw.ip_inc     = 1'b1;
      raw.ir_latch   = 1'b1;
      raw.addr_latch = 1'b1;
    end else if (step == STEP_WIDTH'(STEP_1)) begin
      case (INST)
        OPCODE_WIDTH'(OP_NOP): done = 1'b1;
        OPCODE_WIDTH'(OP_ADD), OPCODE_WIDTH'(OP_SUB): begin
          raw            = fetch_byte();
          raw.a_read_alu = 1'b1;
          raw.a_latch    = 1'b1;
          alu_op = (INST == OPCODE_WIDTH'(OP_ADD)) ? ALU_OP_WIDTH'(ALU_ADD)
                                                   : ALU_OP_WIDTH'(ALU_SUB);
          done = 1'b1;
        end
        OPCODE_WIDTH'(OP_LOD), OPCODE_WIDTH'(OP_STO), OPCODE_WIDTH'(OP_JMP): begin
          raw         = fetch_byte();
          raw.d_latch = 1'b1;
        end
        // Untaken branch finishes here; IP already stepped past the operand.
        OPCODE_WIDTH'(OP_JZ), OPCODE_WIDTH'(OP_JC): begin
          raw         = fetch_byte();
          raw.d_latch = 1'b1;
          done = (INST == OPCODE_WIDTH'(OP_JZ)) ? !FLAG_Z : !FLAG_C;
        end
        OPCODE_WIDTH'(OP_MOVAB): begin
          raw.a_latch  = 1'b1;
          raw.b_enable = 1'b1;
          done = 1'b1;
        end
        OPCODE_WIDTH'(OP_MOVBA): begin
          raw.b_latch  = 1'b1;
          raw.a_enable = 1'b1;
          done = 1'b1;
        end
        OPCODE_WIDTH'(OP_WRITE): begin
          raw          = fetch_byte();
          raw.data_out = 1'b1;
          done = 1'b1;
        end
        OPCODE_WIDTH'(OP_HLT): halt_req = 1'b1;
        default: begin
          illegal_c = 1'b1;
          done      = 1'b1;
        end
      endcase
    end else if (step == STEP_WIDTH'(STEP_2)) begin
      done = 1'b1;
      case (INST)
        OPCODE_WIDTH'(OP_LOD): begin
          raw.d_enable     = 1'b1;
          raw.d_out_select = 1'b1;
          raw.addr_latch   = 1'b1;
          raw.data_in      = 1'b1;
          raw.a_latch      = 1'b1;
        end
        OPCODE_WIDTH'(OP_STO): begin
          raw.d_enable     = 1'b1;
          raw.d_out_select = 1'b1;
          raw.addr_latch   = 1'b1;
          raw.a_enable     = 1'b1;
          raw.data_out     = 1'b1;
        end
        OPCODE_WIDTH'(OP_JMP), OPCODE_WIDTH'(OP_JZ), OPCODE_WIDTH'(OP_JC): begin
          raw.d_enable = 1'b1;
          raw.ip_latch = 1'b1;
        end
        default: done = 1'b1;
      endcase
    end else begin
      done = 1'b1;
    end
  end

  assign mem_step = raw.addr_latch & (raw.data_in | raw.data_out);
  assign stall    = mem_step & !MEM_READY;

  // Reset gates the combinational strobes so nothing leaks while it is held low.
  always_comb begin
    ctrl = '0;
    if (reset) ctrl = stall ? gate_commit(raw) : raw;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        halted <= 1'b0;
    else if (halt_req) halted <= 1'b1;
  end

  step_counter #(.STEP_WIDTH(STEP_WIDTH)) u_step (
    .clk   (clk),
    .reset (reset),
    .hold  (stall | halted | halt_req),
    .done  (done),
    .step  (step)
  );

  assign DATA_IN      = ctrl.data_in;
  assign DATA_OUT     = ctrl.data_out;
  assign A_LATCH      = ctrl.a_latch;
  assign A_ENABLE     = ctrl.a_enable;
  assign A_READ_ALU   = ctrl.a_read_alu;
  assign B_LATCH      = ctrl.b_latch;
  assign B_ENABLE     = ctrl.b_enable;
  assign IP_LATCH     = ctrl.ip_latch;
  assign IP_ENABLE    = ctrl.ip_enable;
  assign IP_INC       = ctrl.ip_inc;
  assign IR_LATCH     = ctrl.ir_latch;
  assign ADDR_LATCH   = ctrl.addr_latch;
  assign D_LATCH      = ctrl.d_latch;
  assign D_ENABLE     = ctrl.d_enable;
  assign D_INC        = ctrl.d_inc;
  assign D_IN_SELECT  = ctrl.d_in_select;
  assign D_OUT_SELECT = ctrl.d_out_select;
  assign ALU_OP       = reset ? alu_op : '0;
  assign HALTED       = halted;
  assign ILLEGAL      = illegal_c & reset;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed plus randomized instruction streams checked cycle by cycle against a step-table model.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] INST = 8'h00;
  logic       MEM_READY = 1'b1;
  logic       FLAG_Z = 1'b0;
  logic       FLAG_C = 1'b0;
  logic       DATA_IN, DATA_OUT, A_LATCH, A_ENABLE, A_READ_ALU, B_LATCH, B_ENABLE;
  logic       IP_LATCH, IP_ENABLE, IP_INC, IR_LATCH, ADDR_LATCH;
  logic       D_LATCH, D_ENABLE, D_INC, D_IN_SELECT, D_OUT_SELECT, HALTED, ILLEGAL;
  logic [3:0] ALU_OP;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .reset(reset), .INST(INST), .MEM_READY(MEM_READY),
    .FLAG_Z(FLAG_Z), .FLAG_C(FLAG_C),
    .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .ALU_OP(ALU_OP),
    .A_LATCH(A_LATCH), .A_ENABLE(A_ENABLE), .A_READ_ALU(A_READ_ALU),
    .B_LATCH(B_LATCH), .B_ENABLE(B_ENABLE),
    .IP_LATCH(IP_LATCH), .IP_ENABLE(IP_ENABLE), .IP_INC(IP_INC),
    .IR_LATCH(IR_LATCH), .ADDR_LATCH(ADDR_LATCH),
    .D_LATCH(D_LATCH), .D_ENABLE(D_ENABLE), .D_INC(D_INC),
    .D_IN_SELECT(D_IN_SELECT), .D_OUT_SELECT(D_OUT_SELECT),
    .HALTED(HALTED), .ILLEGAL(ILLEGAL)
  );

  localparam logic [16:0] M_DIN  = 17'h10000, M_DOUT = 17'h08000, M_AL   = 17'h04000;
  localparam logic [16:0] M_AE   = 17'h02000, M_ARA  = 17'h01000, M_BL   = 17'h00800;
  localparam logic [16:0] M_BE   = 17'h00400, M_IPL  = 17'h00200, M_IPE  = 17'h00100;
  localparam logic [16:0] M_IPI  = 17'h00080, M_IRL  = 17'h00040, M_ADL  = 17'h00020;
  localparam logic [16:0] M_DL   = 17'h00010, M_DE   = 17'h00008, M_DOS  = 17'h00001;
  localparam logic [16:0] M_FB     = M_IPE | M_ADL | M_DIN | M_IPI;
  localparam logic [16:0] M_FETCH  = M_DIN | M_IPE | M_IPI | M_IRL | M_ADL;
  localparam logic [16:0] M_COMMIT = M_IPI | M_IPL | M_IRL | M_AL | M_BL | M_DL;

  function automatic logic [16:0] obs_vec();
    return {DATA_IN, DATA_OUT, A_LATCH, A_ENABLE, A_READ_ALU, B_LATCH, B_ENABLE,
            IP_LATCH, IP_ENABLE, IP_INC, IR_LATCH, ADDR_LATCH,
            D_LATCH, D_ENABLE, D_INC, D_IN_SELECT, D_OUT_SELECT};
  endfunction

  // Instruction table: strobes the programmer's model expects at each step.
  function automatic logic [16:0] step_mask(logic [7:0] op, int s);
    if (s == 0) return M_FETCH;
    if (s == 1) begin
      case (op)
        OP_ADD, OP_SUB:                        return M_FB | M_ARA | M_AL;
        OP_LOD, OP_STO, OP_JMP, OP_JZ, OP_JC:  return M_FB | M_DL;
        OP_MOVAB:                              return M_AL | M_BE;
        OP_MOVBA:                              return M_BL | M_AE;
        OP_WRITE:                              return M_FB | M_DOUT;
        default:                               return 17'h0;
      endcase
    end
    case (op)
      OP_LOD:               return M_DE | M_DOS | M_ADL | M_DIN | M_AL;
      OP_STO:               return M_DE | M_DOS | M_ADL | M_AE | M_DOUT;
      OP_JMP, OP_JZ, OP_JC: return M_DE | M_IPL;
      default:              return 17'h0;
    endcase
  endfunction

  function automatic int last_step(logic [7:0] op, logic taken);
    if (op == OP_LOD || op == OP_STO || op == OP_JMP) return 2;
    if ((op == OP_JZ || op == OP_JC) && taken) return 2;
    return 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Sample mid-cycle, then return just after the next rising edge for new inputs.
  task automatic cycle_check(input string tag, input logic [16:0] m, input logic [3:0] alu,
                             input logic ill, input logic hlt);
    @(negedge clk);
    chk({tag, ".strobes"}, 32'(obs_vec()), 32'(m));
    chk({tag, ".alu_op"}, 32'(ALU_OP), 32'(alu));
    chk({tag, ".illegal"}, 32'(ILLEGAL), 32'(ill));
    chk({tag, ".halted"}, 32'(HALTED), 32'(hlt));
    @(posedge clk);
    #1;
  endtask

  // st0..st2: MEM_READY=0 cycles on each memory step (-1 = random 0..2); fz/fc: -1 = random.
  task automatic run_instr(input logic [7:0] op, input int st0, input int st1, input int st2,
                           input int fz, input int fc);
    logic        z, c, taken, mem, ill;
    logic [16:0] m;
    logic [3:0]  alu;
    int          n, stalls;
    string       tag;
    z = (fz < 0) ? 1'($urandom) : 1'(fz);
    c = (fc < 0) ? 1'($urandom) : 1'(fc);
    taken = (op == OP_JZ) ? z : (op == OP_JC) ? c : 1'b0;
    n = last_step(op, taken);
    for (int s = 0; s <= n; s++) begin
      m   = step_mask(op, s);
      mem = ((m & M_ADL) != 0) && ((m & (M_DIN | M_DOUT)) != 0);
      stalls = (s == 0) ? st0 : (s == 1) ? st1 : st2;
      if (stalls < 0) stalls = $urandom_range(0, 2);
      if (!mem) stalls = 0;
      alu = (s == 1 && op == OP_ADD) ? ALU_ADD : (s == 1 && op == OP_SUB) ? ALU_SUB : 4'h0;
      ill = (s == 1) && (op > OP_HLT);
      INST   = (s == 0) ? 8'($urandom) : op;
      FLAG_Z = (s == 1) ? z : 1'($urandom);
      FLAG_C = (s == 1) ? c : 1'($urandom);
      tag = $sformatf("op%02h.s%0d", op, s);
      for (int k = 0; k < stalls; k++) begin
        MEM_READY = 1'b0;
        cycle_check({tag, ".stall"}, m & ~M_COMMIT, alu, ill, 1'b0);
      end
      MEM_READY = mem ? 1'b1 : 1'($urandom);
      cycle_check(tag, m, alu, ill, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] op;

    // Reset state
    MEM_READY = 1'b1;
    cycle_check("reset", 17'h0, 4'h0, 1'b0, 1'b0);
    MEM_READY = 1'b0;
    cycle_check("reset2", 17'h0, 4'h0, 1'b0, 1'b0);
    reset = 1'b1;

    // Directed programs
    run_instr(OP_ADD,   0, 0, 0, -1, -1);
    run_instr(OP_LOD,   0, 0, 2, -1, -1);
    run_instr(OP_JZ,    0, 0, 0,  0, -1);
    run_instr(OP_JZ,    0, 0, 0,  1, -1);
    run_instr(OP_JC,    0, 0, 0, -1,  0);
    run_instr(OP_JC,    0, 1, 0, -1,  1);
    run_instr(8'hFF,    0, 0, 0, -1, -1);
    run_instr(OP_STO,   0, 0, 1, -1, -1);
    run_instr(OP_SUB,   1, 2, 0, -1, -1);
    run_instr(OP_MOVAB, 0, 0, 0, -1, -1);
    run_instr(OP_MOVBA, 0, 0, 0, -1, -1);
    run_instr(OP_WRITE, 0, 1, 0, -1, -1);
    run_instr(OP_JMP,   2, 0, 0, -1, -1);
    run_instr(OP_NOP,   0, 0, 0, -1, -1);
    run_instr(8'h0C,    0, 0, 0, -1, -1);

    // Random instruction stream, HLT excluded
    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(12, 255)) : 8'($urandom_range(0, 10));
      run_instr(op, -1, -1, -1, -1, -1);
    end

    // Asynchronous reset during LOD step 2
    INST = 8'($urandom); MEM_READY = 1'b1;
    cycle_check("abort.fetch", M_FETCH, 4'h0, 1'b0, 1'b0);
    INST = OP_LOD;
    cycle_check("abort.s1", M_FB | M_DL, 4'h0, 1'b0, 1'b0);
    MEM_READY = 1'b0;
    #1 reset = 1'b0;
    #1 chk("abort.immediate", 32'(obs_vec()), 32'h0);
    MEM_READY = 1'b1;
    cycle_check("abort.held", 17'h0, 4'h0, 1'b0, 1'b0);
    reset = 1'b1;
    run_instr(OP_LOD, 0, 0, 0, -1, -1);

    // Halt: stays halted with all strobes low regardless of inputs
    INST = 8'($urandom); MEM_READY = 1'b1;
    cycle_check("hlt.fetch", M_FETCH, 4'h0, 1'b0, 1'b0);
    INST = OP_HLT;
    cycle_check("hlt.s1", 17'h0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      MEM_READY = 1'($urandom); FLAG_Z = 1'($urandom); FLAG_C = 1'($urandom);
      INST = (i < 10) ? OP_HLT : 8'($urandom);
      cycle_check("hlt.hold", 17'h0, 4'h0, 1'b0, 1'b1);
    end
    reset = 1'b0;
    cycle_check("hlt.reset", 17'h0, 4'h0, 1'b0, 1'b0);
    reset = 1'b1;
    run_instr(OP_ADD, 0, 0, 0, -1, -1);
    run_instr(OP_NOP, 0, 0, 0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
